logs_out_stage: RTL and testbench

// - Output conditioning stage downstream of the logistic-map sonifier.
// - Consumes its 1-bit PWM `snd` stream and box-car averages it into a PCM level.
// - Applies a click-free ramped volume/mute gain, then re-modulates the result

---
 rtl/logs_pkg.sv | 29 ++
 rtl/logs_out_sdm.sv | 53 +++++
 rtl/logs_out_stage.sv | 199 +++++++++++++++++++
 tb/tb_logs_out_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/logs_pkg.sv
// ---------------------------------------------------------------------------
// logs_pkg
// Shared definitions for the logistic-map sonifier output stage.
//   - default widths for the averager and the gain word
//   - FSM state encodings used by logs_out_stage
//   - dither LFSR polynomial/seed and a one-step helper
//     (the helper is only used when LOGS_OUT_DITHER_EN is defined)
// ---------------------------------------------------------------------------
package logs_pkg;

    localparam int LOGS_AVG_BITS = 6;    // log2 of averaging window
    localparam int LOGS_VOL_BITS = 4;    // gain word width
    localparam int LOGS_RAMP_DIV = 256;  // clocks per gain LSB step

    // Galois form of x^16 + x^14 + x^13 + x^11 (right-shifting register).
    localparam logic [15:0] LOGS_LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LOGS_LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        RUN    = 2'd1,
        FADE   = 2'd2
    } logs_state_t;

    function automatic logic [15:0] logs_lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LOGS_LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/logs_out_sdm.sv
// ---------------------------------------------------------------------------
// logs_out_sdm
// First-order sigma-delta modulator. Every clock the level is added into
// an error accumulator; crossing 2^AVG_BITS emits a one and subtracts the
// full-scale value, so the output duty equals level / 2^AVG_BITS.
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   level      in   AVG_BITS+1 bit level (must stay below 2^AVG_BITS)
//   hold_zero  in   1 forces pwm to 0 and keeps the error at 0
//   pwm        out  registered modulator output
// ---------------------------------------------------------------------------
module logs_out_sdm
    import logs_pkg::*;
#(
    parameter int AVG_BITS = LOGS_AVG_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [AVG_BITS:0]   level,
    input  logic                hold_zero,
    output logic                pwm
);

    localparam int              ERR_W = AVG_BITS + 2;
    localparam logic [ERR_W-1:0] FULL = ERR_W'(2 ** AVG_BITS);

    logic [ERR_W-1:0] err_reg;
    logic [ERR_W-1:0] sum;

    // err < 2^AVG_BITS and level < 2^AVG_BITS, so sum never exceeds ERR_W bits.
    always_comb begin
        sum = err_reg + ERR_W'(level);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg <= '0;
            pwm     <= 1'b0;
        end else if (hold_zero) begin
            err_reg <= '0;
            pwm     <= 1'b0;
        end else if (sum >= FULL) begin
            err_reg <= sum - FULL;
            pwm     <= 1'b1;
        end else begin
            err_reg <= sum;
            pwm     <= 1'b0;
        end
    end

endmodule

// File: rtl/logs_out_stage.sv
// ---------------------------------------------------------------------------
// logs_out_stage
// Output conditioning for the logistic-map sonifier: box-car averages the
// 1-bit PWM stream over 2^AVG_BITS clocks, scales the window level by a
// click-free ramped gain, and re-modulates it with a sigma-delta modulator.
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   snd_in     in   PWM audio from the sonifier
//   volume     in   VOL_BITS target gain (0 silent .. 15 = 15/16)
//   mute       in   1 forces the target gain to 0
//   pcm_out    out  AVG_BITS+1 scaled window level (0..60)
//   pcm_valid  out  one-cycle pulse when pcm_out updates
//   silent     out  1 while the FSM is in SILENT
//   pwm_out    out  sigma-delta audio output
//
// Configuration
//   LOGS_OUT_DITHER_EN : when defined, a 16-bit LFSR adds one LSB of
//   dither to each window result (clamped to the maximum level). When
//   undefined the scaled value is passed through exactly.
// ---------------------------------------------------------------------------
module logs_out_stage
    import logs_pkg::*;
#(
    parameter int AVG_BITS = LOGS_AVG_BITS,
    parameter int VOL_BITS = LOGS_VOL_BITS,
    parameter int RAMP_DIV = LOGS_RAMP_DIV
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                snd_in,
    input  logic [VOL_BITS-1:0] volume,
    input  logic                mute,
    output logic [AVG_BITS:0]   pcm_out,
    output logic                pcm_valid,
    output logic                silent,
    output logic                pwm_out
);

    localparam int RC_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int PROD_W = AVG_BITS + 1 + VOL_BITS;

    // Full window times maximum gain, i.e. 64 * 15 / 16 = 60 by default.
    localparam logic [AVG_BITS:0] PCM_MAX =
        (AVG_BITS + 1)'(((2 ** AVG_BITS) * (2 ** VOL_BITS - 1)) / (2 ** VOL_BITS));

    logic [AVG_BITS-1:0] wc_reg;
    logic [AVG_BITS:0]   acc_reg;
    logic [RC_W-1:0]     rc_reg;
    logic [VOL_BITS-1:0] cur_gain_reg;
    logs_state_t         state_reg;

    logic                window_end;
    logic                ramp_tick;
    logic [VOL_BITS-1:0] target;
    logic [AVG_BITS:0]   sample;
    logic [PROD_W-1:0]   product;
    logic [AVG_BITS:0]   scaled;
    logic [AVG_BITS:0]   pcm_next;

    // -----------------------------------------------------------------------
    // Window averaging and scaling
    // -----------------------------------------------------------------------
    always_comb begin
        window_end = &wc_reg;
        target     = mute ? '0 : volume;
        ramp_tick  = (rc_reg == RC_W'(RAMP_DIV - 1));
        // The final cycle of the window is counted directly so that the
        // accumulator can clear on the same edge the sample is taken.
        sample     = acc_reg + {{AVG_BITS{1'b0}}, snd_in};
        // Uses the gain held before any ramp step landing on this edge.
        product    = PROD_W'(sample) * PROD_W'(cur_gain_reg);
        scaled     = (AVG_BITS + 1)'(product >> VOL_BITS);
    end

`ifdef LOGS_OUT_DITHER_EN
    logic [15:0]       lfsr_reg;
    logic [AVG_BITS+1:0] dithered;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= LOGS_LFSR_SEED;
        end else begin
            lfsr_reg <= logs_lfsr_step(lfsr_reg);
        end
    end

    always_comb begin
        dithered = {1'b0, scaled} + {{(AVG_BITS + 1){1'b0}}, lfsr_reg[0]};
        pcm_next = (dithered > {1'b0, PCM_MAX}) ? PCM_MAX : dithered[AVG_BITS:0];
    end
`else
    always_comb begin
        pcm_next = scaled;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wc_reg    <= '0;
            acc_reg   <= '0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
        end else begin
            wc_reg <= wc_reg + 1'b1;
            if (window_end) begin
                acc_reg   <= '0;
                pcm_out   <= pcm_next;
                pcm_valid <= 1'b1;
            end else begin
                acc_reg   <= sample;
                pcm_valid <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Gain ramp: one LSB toward the target per tick, so a retarget mid-ramp
    // simply changes direction on the next tick without a jump.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rc_reg       <= '0;
            cur_gain_reg <= '0;
        end else begin
            rc_reg <= ramp_tick ? '0 : rc_reg + 1'b1;
            if (ramp_tick) begin
                if (cur_gain_reg < target) begin
                    cur_gain_reg <= cur_gain_reg + 1'b1;
                end else if (cur_gain_reg > target) begin
                    cur_gain_reg <= cur_gain_reg - 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Operating-state FSM with registered silent flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= SILENT;
            silent    <= 1'b1;
        end else begin
            case (state_reg)
                SILENT: begin
                    if (target != '0) begin
                        state_reg <= RUN;
                        silent    <= 1'b0;
                    end
                end
                RUN: begin
                    if (mute && (cur_gain_reg != '0)) begin
                        state_reg <= FADE;
                        silent    <= 1'b0;
                    end else if ((target == '0) && (cur_gain_reg == '0)) begin
                        state_reg <= SILENT;
                        silent    <= 1'b1;
                    end
                end
                FADE: begin
                    if (!mute) begin
                        // Unmuting resumes from the current gain; only drop
                        // to SILENT if there is nothing left to play.
                        if ((target != '0) || (cur_gain_reg != '0)) begin
                            state_reg <= RUN;
                            silent    <= 1'b0;
                        end else begin
                            state_reg <= SILENT;
                            silent    <= 1'b1;
                        end
                    end else if (cur_gain_reg == '0) begin
                        state_reg <= SILENT;
                        silent    <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= SILENT;
                    silent    <= 1'b1;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Sigma-delta re-modulation
    // -----------------------------------------------------------------------
    logs_out_sdm #(
        .AVG_BITS (AVG_BITS)
    ) u_sdm (
        .clk       (clk),
        .reset     (reset),
        .level     (pcm_out),
        .hold_zero (state_reg == SILENT),
        .pwm       (pwm_out)
    );

endmodule

// File: tb/tb_logs_out_stage.sv
// ---------------------------------------------------------------------------
// tb_logs_out_stage
// Directed bench for logs_out_stage. Edges are counted from reset release
// (cyc = number of rising edges seen); ramp ticks land on multiples of 256
// and window ends on multiples of 64, so expected levels are 4 * gain with
// snd_in held high and 16 for a half-duty stream at gain 8.
// ---------------------------------------------------------------------------
module tb_logs_out_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       snd_in;
    logic [3:0] volume;
    logic       mute;
    logic [6:0] pcm_out;
    logic       pcm_valid;
    logic       silent;
    logic       pwm_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit toggle = 1'b0;
    int ones;
    int valids;
    int found;
    int nonzero;

    logs_out_stage dut (
        .clk       (clk),
        .reset     (reset),
        .snd_in    (snd_in),
        .volume    (volume),
        .mute      (mute),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid),
        .silent    (silent),
        .pwm_out   (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (toggle) snd_in = ~snd_in;
    endtask

    task automatic run_to(input int target_cyc);
        while (cyc < target_cyc) tick();
    endtask

    task automatic count_window(output int n_ones, output int n_valid);
        n_ones  = 0;
        n_valid = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            n_ones  += int'(pwm_out);
            n_valid += int'(pcm_valid);
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset  = 1'b1;
        snd_in = 1'b1;
        volume = 4'd15;
        mute   = 1'b0;
        #1;
        check("rst_pcm_out", pcm_out, 0);
        check("rst_pcm_valid", pcm_valid, 0);
        check("rst_pwm_out", pwm_out, 0);
        check("rst_silent", silent, 1);
        tick();
        tick();
        reset = 1'b0;
        cyc   = 0;

        // ---------------- ramp up 0 -> 15 ----------------
        tick();
        check("ramp_run_after_1", silent, 0);
        run_to(256);
        check("ramp_w256_pcm", pcm_out, 0);
        check("ramp_w256_valid", pcm_valid, 1);
        tick();
        check("ramp_257_valid", pcm_valid, 0);
        run_to(1024);
        check("ramp_w1024_pcm", pcm_out, 12);
        run_to(3840);
        check("ramp_w3840_pre_tick", pcm_out, 56);
        run_to(3904);
        check("ramp_w3904_full", pcm_out, 60);
        $display("txn ramp_up: cyc=%0d pcm_out=%0d", cyc, pcm_out);
        count_window(ones, valids);
        check("ramp_pwm_ones", ones, 60);
        check("ramp_valid_count", valids, 1);

        // ---------------- half scale ----------------
        volume = 4'd8;
        toggle = 1'b1;
        run_to(6400);
        check("half_pcm", pcm_out, 16);
        count_window(ones, valids);
        check("half_pwm_ones", ones, 16);
        check("half_valid_count", valids, 1);
        $display("txn half_scale: cyc=%0d pcm_out=%0d ones=%0d", cyc, pcm_out, ones);

        // ---------------- mute fade ----------------
        toggle = 1'b0;
        snd_in = 1'b1;
        volume = 4'd15;
        run_to(8256);
        check("mute_pre_pcm", pcm_out, 60);
        mute = 1'b1;
        run_to(8512);
        check("fade_w8512_pcm", pcm_out, 56);
        check("fade_silent_mid", silent, 0);
        run_to(12032);
        check("fade_silent_last", silent, 0);
        tick();
        check("fade_silent_set", silent, 1);
        count_window(ones, valids);
        check("silent_pwm_ones", ones, 0);
        check("silent_pcm", pcm_out, 0);
        $display("txn mute: cyc=%0d silent=%0d ones=%0d", cyc, silent, ones);

        // ---------------- unmute mid-fade ----------------
        mute = 1'b0;
        tick();
        check("unmute_run", silent, 0);
        run_to(15872);
        mute = 1'b1;
        run_to(16192);
        check("refade_w16192", pcm_out, 56);
        run_to(17930);
        mute = 1'b0;
        run_to(18176);
        check("unmute_w18176_g7", pcm_out, 28);
        run_to(18240);
        check("unmute_w18240_g8", pcm_out, 32);
        check("unmute_silent", silent, 0);
        run_to(20032);
        check("unmute_full", pcm_out, 60);
        $display("txn unmute: cyc=%0d pcm_out=%0d", cyc, pcm_out);

        // ---------------- async reset mid-window ----------------
        run_to(20050);
        #3;
        reset = 1'b1;
        #1;
        check("arst_pcm_out", pcm_out, 0);
        check("arst_pwm_out", pwm_out, 0);
        check("arst_silent", silent, 1);
        check("arst_pcm_valid", pcm_valid, 0);
        #2;
        reset = 1'b0;
        cyc   = 0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (pcm_valid) begin
                found = cyc;
                break;
            end
        end
        check("arst_first_valid_cyc", found, 64);
        $display("txn async_reset: first pcm_valid at cyc=%0d", found);

        // ---------------- dither ----------------
        snd_in  = 1'b0;
        volume  = 4'd15;
        nonzero = 0;
        for (int w = 0; w < 64; w++) begin
            for (int i = 0; i < 64; i++) begin
                tick();
                if (pcm_valid && (pcm_out != 7'd0)) nonzero++;
            end
        end
`ifdef LOGS_OUT_DITHER_EN
        check("dither_nonzero_seen", (nonzero > 0), 1);
`else
        check("nodither_nonzero_windows", nonzero, 0);
`endif
        $display("txn dither: nonzero windows=%0d", nonzero);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
